// File: rtl/add_rs_dispatch.sv
// Add/sub reservation station: CDB wakeup, oldest-ready select, one-cycle dispatch strobe.
// Optional ADD_RS_CDB_WAKE_DISPATCH_EN lets a CDB-completed entry dispatch on the same edge.
module add_rs_dispatch #(
    parameter int ENTRIES = 3,
    parameter int DATA_W  = 8,
    parameter int TAG_W   = 3,
    parameter int REG_W   = 4
) (
    input  logic              clk2,
    input  logic              rst,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic [3:0]        issue_func,
    input  logic [REG_W-1:0]  issue_rd,
    input  logic [TAG_W-1:0]  issue_rob,
    input  logic              issue_s1_rdy,
    input  logic              issue_s2_rdy,
    input  logic [DATA_W-1:0] issue_s1_val,
    input  logic [DATA_W-1:0] issue_s2_val,
    input  logic [TAG_W-1:0]  issue_s1_tag,
    input  logic [TAG_W-1:0]  issue_s2_tag,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    input  logic              flush,
    input  logic              ex_busy,
    output logic              ex_b,
    output logic [2:0]        rs_index,
    output logic [DATA_W-1:0] rs1_data,
    output logic [DATA_W-1:0] rs2_data,
    output logic [3:0]        func,
    output logic [REG_W-1:0]  rd,
    output logic [TAG_W-1:0]  rob_ind,
    output logic [2:0]        occupancy
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam logic [2:0] DEPTH = 3'(ENTRIES);

    logic [ENTRIES-1:0] valid;
    logic [ENTRIES-1:0] s1_rdy;
    logic [ENTRIES-1:0] s2_rdy;
    logic [3:0]         e_func [ENTRIES];
    logic [REG_W-1:0]   e_rd   [ENTRIES];
    logic [TAG_W-1:0]   e_rob  [ENTRIES];
    logic [DATA_W-1:0]  s1_val [ENTRIES];
    logic [DATA_W-1:0]  s2_val [ENTRIES];
    logic [TAG_W-1:0]   s1_tag [ENTRIES];
    logic [TAG_W-1:0]   s2_tag [ENTRIES];
    logic [2:0]         age    [ENTRIES];
    logic [2:0]         count;

    logic [ENTRIES-1:0] hit1;
    logic [ENTRIES-1:0] hit2;
    logic [ENTRIES-1:0] cand;
    logic [DATA_W-1:0]  op1 [ENTRIES];
    logic [DATA_W-1:0]  op2 [ENTRIES];

    logic             sel_found;
    logic [IDX_W-1:0] sel_idx;
    logic [2:0]       sel_age;
    logic [IDX_W-1:0] free_idx;
    logic             fire;
    logic             accept;
    logic [2:0]       new_age;
    logic             new_s1_rdy;
    logic             new_s2_rdy;
    logic [DATA_W-1:0] new_s1_val;
    logic [DATA_W-1:0] new_s2_val;

    assign issue_ready = (count < DEPTH);
    assign occupancy   = count;

    always_comb begin
        hit1 = '0;
        hit2 = '0;
        cand = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            hit1[i] = cdb_valid && !s1_rdy[i] && (s1_tag[i] == cdb_tag);
            hit2[i] = cdb_valid && !s2_rdy[i] && (s2_tag[i] == cdb_tag);
`ifdef ADD_RS_CDB_WAKE_DISPATCH_EN
            cand[i] = valid[i] && (s1_rdy[i] || hit1[i])
                    && (s2_rdy[i] || hit2[i]);
            op1[i]  = s1_rdy[i] ? s1_val[i] : cdb_data;
            op2[i]  = s2_rdy[i] ? s2_val[i] : cdb_data;
`else
            cand[i] = valid[i] && s1_rdy[i] && s2_rdy[i];
            op1[i]  = s1_val[i];
            op2[i]  = s2_val[i];
`endif
        end
    end

    // Ages are unique among valid entries, so the minimum is unambiguous.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_age   = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (cand[i] && (!sel_found || age[i] < sel_age)) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
                sel_age   = age[i];
            end
        end
    end

    always_comb begin
        free_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                free_idx = IDX_W'(i);
            end
        end
    end

    assign fire    = sel_found && !ex_busy && !ex_b;
    assign accept  = issue_valid && issue_ready;
    assign new_age = fire ? (count - 3'd1) : count;

    assign new_s1_rdy = issue_s1_rdy
                      || (cdb_valid && issue_s1_tag == cdb_tag);
    assign new_s2_rdy = issue_s2_rdy
                      || (cdb_valid && issue_s2_tag == cdb_tag);
    assign new_s1_val = issue_s1_rdy ? issue_s1_val : cdb_data;
    assign new_s2_val = issue_s2_rdy ? issue_s2_val : cdb_data;

    always_ff @(posedge clk2) begin
        if (rst) begin
            valid    <= '0;
            count    <= '0;
            ex_b     <= 1'b0;
            rs_index <= '0;
            rs1_data <= '0;
            rs2_data <= '0;
            func     <= '0;
            rd       <= '0;
            rob_ind  <= '0;
        end else if (flush) begin
            valid <= '0;
            count <= '0;
            ex_b  <= 1'b0;
        end else begin
            ex_b <= fire;
            for (int i = 0; i < ENTRIES; i++) begin
                if (valid[i] && hit1[i]) begin
                    s1_rdy[i] <= 1'b1;
                    s1_val[i] <= cdb_data;
                end
                if (valid[i] && hit2[i]) begin
                    s2_rdy[i] <= 1'b1;
                    s2_val[i] <= cdb_data;
                end
                if (fire && valid[i] && age[i] > sel_age) begin
                    age[i] <= age[i] - 3'd1;
                end
            end
            if (fire) begin
                valid[sel_idx] <= 1'b0;
                rs_index       <= 3'(sel_idx);
                rs1_data       <= op1[sel_idx];
                rs2_data       <= op2[sel_idx];
                func           <= e_func[sel_idx];
                rd             <= e_rd[sel_idx];
                rob_ind        <= e_rob[sel_idx];
            end
            // The free slot is never the dispatched one: it was already invalid.
            if (accept) begin
                valid[free_idx]  <= 1'b1;
                e_func[free_idx] <= issue_func;
                e_rd[free_idx]   <= issue_rd;
                e_rob[free_idx]  <= issue_rob;
                s1_rdy[free_idx] <= new_s1_rdy;
                s2_rdy[free_idx] <= new_s2_rdy;
                s1_val[free_idx] <= new_s1_val;
                s2_val[free_idx] <= new_s2_val;
                s1_tag[free_idx] <= issue_s1_tag;
                s2_tag[free_idx] <= issue_s2_tag;
                age[free_idx]    <= new_age;
            end
            count <= count + {2'b00, accept} - {2'b00, fire};
        end
    end

endmodule

// File: doc/add_rs_dispatch.md
# add_rs_dispatch

Three-entry reservation station for the add/sub class. It sits directly upstream of the add execution unit. It accepts renamed instructions from issue and captures operand values broadcast on the common data bus (CDB). It dispatches the oldest fully-ready entry to the execution unit with a one-cycle `ex_b` pulse, and holds all operand and destination fields stable until the next dispatch.

## Interface
- `ENTRIES`, 3: station depth, 2..7.
- `DATA_W`, 8: operand width.
- `TAG_W`, 3: ROB index and tag width.
- `REG_W`, 4: architectural register index width.

- `clk2`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `issue_valid`  in  1  issue offers an instruction.
- `issue_ready`  out  1  station not full; the instruction is accepted on an edge where `issue_valid && issue_ready`.
- `issue_func`  in  4  `0000` add, `0001` sub; other codes are accepted and passed through unchanged.
- `issue_rd`  in  `REG_W`  destination register.
- `issue_rob`  in  `TAG_W`  ROB index.
- `issue_s1_rdy`, `issue_s2_rdy`  in  1  operand value is already valid.
- `issue_s1_val`, `issue_s2_val`  in  `DATA_W`  operand value, used when rdy=1.
- `issue_s1_tag`, `issue_s2_tag`  in  `TAG_W`  producing ROB tag, used when rdy=0.
- `cdb_valid`  in  1  CDB broadcast is valid this cycle.
- `cdb_tag`  in  `TAG_W`  ROB tag of the broadcast result.
- `cdb_data`  in  `DATA_W`  broadcast result.
- `flush`  in  1  discard all entries.
- `ex_busy`  in  1  execution unit occupied (level).
- `ex_b`  out  1  dispatch strobe; one-cycle pulse.
- `rs_index`  out  3  dispatched entry slot.
- `rs1_data`, `rs2_data`  out  `DATA_W`  operands.
- `func`  out  4  dispatched function code.
- `rd`  out  `REG_W`  dispatched destination register.
- `rob_ind`  out  `TAG_W`  dispatched ROB index.
- `occupancy`  out  3  number of valid entries.

## Operation
- Entry fields: valid, func, rd, rob, per operand {rdy, val, tag}, and age (0 = oldest).
- **Issue**
  - Write to the lowest-numbered free slot.
  - Age = current occupancy.
  - If `cdb_valid` and an operand tag equals `cdb_tag` while rdy=0 in the same cycle, capture `cdb_data` and set rdy=1 (issue-time bypass, always on).
- **Wakeup:** every valid entry operand with rdy=0 and tag==`cdb_tag` captures `cdb_data` and sets rdy=1 when `cdb_valid`.
- **Select**
  - Candidates: entries that are valid with both operands rdy.
  - Choose minimum age; ties cannot occur.
- **Dispatch**
  - Occurs on an edge where a candidate exists, `ex_busy==0`, and `ex_b==0`. No back-to-back dispatch; the exec unit raises busy one cycle after the strobe.
  - Effects: register the output fields, pulse `ex_b`, invalidate the slot, and decrement the age of every entry older-numbered (age greater than the dispatched age).
- Simultaneous issue and dispatch on one edge are both performed.
  - The new entry's age = occupancy − 1.
  - The new entry is not a candidate on that edge.
- Occupancy counts 0..`ENTRIES`, with no wrap.
- Arithmetic is not performed here; values are passed unmodified.
- **Flush:** clears all valid bits and occupancy, and forces `ex_b`=0. A dispatch or issue on the same edge is dropped; flush has priority.
- **Reset:** same effect as flush, and additionally clears every output field.

## Timing
- Reset values:
  - `ex_b`=0, `issue_ready`=1, `occupancy`=0.
  - `rs_index`, `rs1_data`, `rs2_data`, `func`, `rd`, `rob_ind` all 0.
- `issue_ready` = (occupancy < `ENTRIES`), derived from registered state only; it gives no credit for a dispatch on the same edge.
- Fully-ready issue at edge N → earliest `ex_b` at edge N+1 (visible in cycle N+1).
- Operand woken by CDB at edge N → entry becomes a candidate at edge N+1.
- `ex_b` high for exactly one cycle; output fields hold until the next dispatch or reset.
- Full station with `issue_valid` held: the instruction is accepted on the first edge after a dispatch frees a slot.
- Reset asserted mid-operation: all state is cleared at that edge; pending CDB data is lost.

## Configuration
- `ADD_RS_CDB_WAKE_DISPATCH_EN`
  - **Defined:** an entry whose last missing operand matches the current CDB broadcast is a candidate on the same edge. The dispatched operand takes `cdb_data` directly, saving one cycle.
  - **Undefined:** wakeup and dispatch are separated by one edge, as stated in Timing.

## Test plan
- Reset, then issue add (`rd`=3, rob=1, 5 and 7 both ready) with `ex_busy`=0 → `ex_b` pulse in cycle after issue; `rs1_data`=5, `rs2_data`=7, `func`=0000, `rob_ind`=1.
- Issue three entries, each with s1 waiting on tags 4/5/6; broadcast tag 6 then tag 4 → dispatch order rob of tag-6 entry first, then tag-4 entry; operands carry `cdb_data`.
- Fill 3 entries with `ex_busy`=1 → `issue_ready`=0, fourth issue held; drop busy → oldest dispatched, fourth accepted next edge, `occupancy` returns to 3.
- Issue with s2 tag=2 while `cdb_valid`, tag 2, data 0x2A in the same cycle → entry captures 0x2A; dispatched `rs2_data`=0x2A.
- Assert `flush` on the same edge as a ready dispatch and a new issue → `ex_b` stays 0, `occupancy`=0, `issue_ready`=1.
- With macro defined, the CDB completing the last operand at edge N → `ex_b` at N with forwarded value. Without the macro → `ex_b` at N+1.
